// File: rtl/msrv32_pkg.sv
// Shared MSRV32 definitions: store size codes, AHB transfer codes
// and the store-entry record used by buffered store units.
package msrv32_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Widest store entry; narrower cores keep the low XLEN bits.
  typedef struct packed {
    logic [XLEN_MAX-1:0]   addr;
    logic [XLEN_MAX-1:0]   data;
    logic [XLEN_MAX/8-1:0] mask;
  } st_entry_t;

endpackage

// File: rtl/msrv32_store_lane_align.sv
// Store misalign check plus byte-lane steering of data and mask.
// In: req_i, funct3_i, addr_i, data_i. Out: misaligned_o, addr_o, data_o, mask_o.
module msrv32_store_lane_align
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              req_i,
  input  logic [1:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   data_i,
  output logic              misaligned_o,
  output logic [XLEN-1:0]   addr_o,
  output logic [XLEN-1:0]   data_o,
  output logic [XLEN/8-1:0] mask_o
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic [OW-1:0]   off;
  logic [31:0]     sz_b;
  logic [NB-1:0]   lanes;
  logic [XLEN-1:0] keep;
  logic            unal;
  logic            oversize;

  assign off = addr_i[OW-1:0];

  always_comb begin
    sz_b = 32'd1;
    unique case (funct3_i)
      SZ_BYTE:   sz_b = 32'd1;
      SZ_HALF:   sz_b = 32'd2;
      SZ_WORD:   sz_b = 32'd4;
      SZ_DOUBLE: sz_b = 32'd8;
      default:   sz_b = 32'd1;
    endcase
  end

  assign oversize = sz_b > NB;
  assign unal     = |(32'(off) & (sz_b - 32'd1));
  assign lanes    = NB'((32'd1 << sz_b) - 32'd1);

  // Expand the per-byte enable into a bit mask that trims rs2.
  always_comb begin
    keep = '0;
    for (int b = 0; b < NB; b++)
      keep[b*8 +: 8] = {8{lanes[b]}};
  end

  assign misaligned_o = req_i & (unal | oversize);
  assign addr_o = {addr_i[XLEN-1:OW], {OW{1'b0}}};
  assign data_o = (data_i & keep) << {off, 3'b000};
  assign mask_o = lanes << off;

endmodule

// File: rtl/msrv32_store_buffer.sv
// In-order store buffer between execute and the AHB data port.
// Ports: store request in, ready/misaligned out, head write to AHB, occupancy.
module msrv32_store_buffer
  import msrv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     ms_riscv32_mp_clk_in,
  input  logic                     ms_riscv32_mp_rst_in,
  input  logic [2:0]               funct3_in,
  input  logic [XLEN-1:0]          iadder_in,
  input  logic [XLEN-1:0]          rs2_in,
  input  logic                     mem_wr_req_in,
  output logic                     st_ready_out,
  output logic                     st_misaligned_out,
  input  logic                     ahb_ready_in,
  output logic [XLEN-1:0]          ms_riscv32_mp_dmaddr_out,
  output logic [XLEN-1:0]          ms_riscv32_mp_dmdata_out,
  output logic [XLEN/8-1:0]        ms_riscv32_mp_dmwr_mask_out,
  output logic                     ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]               ahb_htrans_out,
  output logic                     sb_empty_out,
  output logic [$clog2(DEPTH):0]   sb_count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] mask;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        new_e;
  entry_t        head;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq, empty;

  // Bit 2 of funct3 selects signedness for loads only.
  logic unused_f3;
  assign unused_f3 = funct3_in[2];

  msrv32_store_lane_align #(.XLEN(XLEN)) u_align (
    .req_i        (mem_wr_req_in),
    .funct3_i     (funct3_in[1:0]),
    .addr_i       (iadder_in),
    .data_i       (rs2_in),
    .misaligned_o (st_misaligned_out),
    .addr_o       (new_e.addr),
    .data_o       (new_e.data),
    .mask_o       (new_e.mask)
  );

  assign empty        = (count_q == '0);
  assign st_ready_out = (count_q != CW'(DEPTH));
  assign enq = mem_wr_req_in & st_ready_out & ~st_misaligned_out;
  assign deq = ~empty & ahb_ready_in;

  assign wptr_d = enq ? PW'(wptr_q + 1'b1) : wptr_q;
  assign rptr_d = deq ? PW'(rptr_q + 1'b1) : rptr_q;

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (enq && !ms_riscv32_mp_rst_in)
      mem_q[wptr_q] <= new_e;
  end

  assign head = empty ? '0 : mem_q[rptr_q];

  assign ms_riscv32_mp_dmaddr_out    = head.addr;
  assign ms_riscv32_mp_dmdata_out    = head.data;
  assign ms_riscv32_mp_dmwr_mask_out = head.mask;
  assign ms_riscv32_mp_dmwr_req_out  = ~empty;
  assign ahb_htrans_out = empty ? HTRANS_IDLE : HTRANS_NONSEQ;
  assign sb_empty_out   = empty;
  assign sb_count_out   = count_q;

endmodule
